// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
//   Single-clock FIFO with a show-ahead read port, registered full/empty flags
//   and protection against overflow and underflow. Pointers carry one extra
//   wrap bit so that full and empty can be told apart with no spare entry.
//
// Configuration macro:
//   FIFO_LEVEL_EN : when defined, adds the registered occupancy output O_level.
//
// Ports:
//   I_clk     in   1        clock, rising edge
//   I_rst     in   1        synchronous reset, active high
//   I_winc    in   1        write request (accepted when not full)
//   I_wdata   in   DSIZE    write data
//   O_wfull   out  1        FIFO full (registered)
//   I_rinc    in   1        read request (accepted when not empty)
//   O_rdata   out  DSIZE    head-of-FIFO data, zero while empty
//   O_rempty  out  1        FIFO empty (registered)
//   O_level   out  ASIZE+1  occupancy, only with FIFO_LEVEL_EN
// -----------------------------------------------------------------------------
module sync_fifo_ctrl #(
    parameter int ASIZE = 10,
    parameter int DSIZE = 8
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_winc,
    input  logic [DSIZE-1:0] I_wdata,
    output logic             O_wfull,
    input  logic             I_rinc,
    output logic [DSIZE-1:0] O_rdata,
    output logic             O_rempty
`ifdef FIFO_LEVEL_EN
    ,
    output logic [ASIZE:0]   O_level
`endif
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem_r [0:DEPTH-1];
    logic [ASIZE:0]   wptr_r;
    logic [ASIZE:0]   rptr_r;
    logic [ASIZE:0]   wptr_next_s;
    logic [ASIZE:0]   rptr_next_s;
    logic             wen_s;
    logic             ren_s;

    // Accept decisions and next-state pointers; flags are derived from these
    // so they never lag the true occupancy.
    always_comb begin
        wen_s       = I_winc & ~O_wfull;
        ren_s       = I_rinc & ~O_rempty;
        wptr_next_s = wptr_r + {{ASIZE{1'b0}}, wen_s};
        rptr_next_s = rptr_r + {{ASIZE{1'b0}}, ren_s};
    end

    // Storage write port; contents are never cleared, reset only blocks the write.
    always_ff @(posedge I_clk) begin
        if (wen_s && !I_rst) begin
            mem_r[wptr_r[ASIZE-1:0]] <= I_wdata;
        end
    end

    // Pointer and flag registers with synchronous reset.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            wptr_r   <= {(ASIZE+1){1'b0}};
            rptr_r   <= {(ASIZE+1){1'b0}};
            O_rempty <= 1'b1;
            O_wfull  <= 1'b0;
        end else begin
            wptr_r   <= wptr_next_s;
            rptr_r   <= rptr_next_s;
            O_rempty <= (wptr_next_s == rptr_next_s);
            // Same address with opposite wrap bit: writer is a full lap ahead.
            O_wfull  <= (wptr_next_s == {~rptr_next_s[ASIZE], rptr_next_s[ASIZE-1:0]});
        end
    end

`ifdef FIFO_LEVEL_EN
    // Registered occupancy, updated alongside the flags.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            O_level <= {(ASIZE+1){1'b0}};
        end else begin
            O_level <= wptr_next_s - rptr_next_s;
        end
    end
`endif

    // Show-ahead read data; held at zero while empty so stale words never leak.
    always_comb begin
        if (O_rempty) begin
            O_rdata = {DSIZE{1'b0}};
        end else begin
            O_rdata = mem_r[rptr_r[ASIZE-1:0]];
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_ctrl
//   Self-checking bench for sync_fifo_ctrl. A queue holds the words the bench
//   expects the FIFO to contain; accepted writes push, accepted reads pop and
//   compare against O_rdata. Flags (and O_level when FIFO_LEVEL_EN is defined)
//   are compared against the bench's own occupancy count every cycle.
// -----------------------------------------------------------------------------
module tb_sync_fifo_ctrl;

    localparam int ASIZE = 10;
    localparam int DSIZE = 8;
    localparam int DEPTH = 1 << ASIZE;

    logic             clk;
    logic             rst;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
`ifdef FIFO_LEVEL_EN
    logic [ASIZE:0]   level;
`endif

    int total_cnt = 0;
    int bad_cnt   = 0;
    int level_m   = 0;
    logic [DSIZE-1:0] sb_q[$];

    sync_fifo_ctrl #(.ASIZE(ASIZE), .DSIZE(DSIZE)) dut (
        .I_clk    (clk),
        .I_rst    (rst),
        .I_winc   (winc),
        .I_wdata  (wdata),
        .O_wfull  (wfull),
        .I_rinc   (rinc),
        .O_rdata  (rdata),
        .O_rempty (rempty)
`ifdef FIFO_LEVEL_EN
        ,
        .O_level  (level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Flags, empty-data and occupancy against the bench's occupancy count.
    task automatic check_state(input string tag);
        check_val({tag, ".rempty"}, int'(rempty), (level_m == 0) ? 1 : 0);
        check_val({tag, ".wfull"},  int'(wfull),  (level_m == DEPTH) ? 1 : 0);
        if (level_m == 0) check_val({tag, ".rdata0"}, int'(rdata), 0);
`ifdef FIFO_LEVEL_EN
        check_val({tag, ".level"}, int'(level), level_m);
`endif
    endtask

    // One clock cycle of stimulus, entered and left at a falling edge.
    task automatic cycle(input logic w, input logic [DSIZE-1:0] d, input logic r, input string tag);
        logic wacc;
        logic racc;
        winc = w;
        wdata = d;
        rinc = r;
        wacc = w && (level_m < DEPTH);
        racc = r && (level_m > 0);
        if (racc) check_val({tag, ".rdata"}, int'(rdata), int'(sb_q[0]));
        @(posedge clk);
        if (racc) begin
            void'(sb_q.pop_front());
            level_m--;
        end
        if (wacc) begin
            sb_q.push_back(d);
            level_m++;
        end
        @(negedge clk);
        winc = 1'b0;
        rinc = 1'b0;
        check_state(tag);
    endtask

    // Reset for n cycles; requests held high when 'busy' to test reset priority.
    task automatic do_reset(input int n, input logic busy);
        rst = 1'b1;
        winc = busy;
        rinc = busy;
        wdata = 8'hA5;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        winc = 1'b0;
        rinc = 1'b0;
        sb_q.delete();
        level_m = 0;
        check_state("reset");
    endtask

    task automatic drain(input string tag);
        while (level_m > 0) cycle(1'b0, 8'h00, 1'b1, tag);
    endtask

    initial begin
        rst = 1'b1;
        winc = 1'b0;
        rinc = 1'b0;
        wdata = 8'h00;

        // 1: reset, then idle
        do_reset(3, 1'b0);
        repeat (3) cycle(1'b0, 8'h00, 1'b0, "idle");

        // 2: write 1..30, reads start 10 cycles later
        for (int i = 0; i < 40; i++)
            cycle(i < 30, 8'(i + 1), i >= 10, "t2");
        check_val("t2.empty_end", int'(rempty), 1);

        // 3: 80 writes, 81 reads; extra read must not move the pointer
        for (int i = 0; i < 80; i++) cycle(1'b1, 8'(i + 1), 1'b0, "t3w");
        for (int i = 0; i < 81; i++) cycle(1'b0, 8'h00, 1'b1, "t3r");
        check_val("t3.empty_end", int'(rempty), 1);
        cycle(1'b1, 8'h77, 1'b0, "t3p");
        cycle(1'b0, 8'h00, 1'b1, "t3p");

        // 4: overflow: 1025 writes, the last is dropped
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 8'(i + 1), 1'b0, "t4w");
        check_val("t4.full", int'(wfull), 1);
        check_val("t4.sbsize", sb_q.size(), DEPTH);
        drain("t4r");

        // 5: simultaneous request at full and at empty
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i + 3), 1'b0, "t5w");
        cycle(1'b1, 8'hEE, 1'b1, "t5full");
        check_val("t5.level_full", level_m, DEPTH - 1);
        check_val("t5.wfull_clr", int'(wfull), 0);
        drain("t5r");
        cycle(1'b1, 8'h5A, 1'b1, "t5empty");
        check_val("t5.rempty_clr", int'(rempty), 0);
        drain("t5r2");

        // 6: move pointers near the wrap, then stream 90 words across it
        do_reset(1, 1'b0);
        for (int i = 0; i < 1000; i++) cycle(1'b1, 8'(i), i > 0, "t6pre");
        drain("t6pre");
        for (int i = 0; i < 91; i++) cycle(i < 90, 8'(i + 1), i > 0, "t6wrap");
        check_val("t6.empty_wrap", int'(rempty), 1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(i + 100), i > 4, "t6mid");
        do_reset(1, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i + 200), 1'b0, "t6post");
        drain("t6post");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock first-in/first-out buffer with a show-ahead read port, full/empty flags and overflow/underflow protection. It replaces the dual-clock FIFO in the write-to-read data path where both sides share one clock domain. The write side pushes on I_winc and the read side pops on I_rinc. It is the reference-checked buffer between a streaming producer and a consumer.

Parameters:
ASIZE, 10, address width; depth = 2**ASIZE entries (1024).
DSIZE, 8, data word width in bits.

Ports:
I_clk  input  1  single clock, rising-edge.
I_rst  input  1  synchronous reset, active-high.
I_winc  input  1  write request; pushes I_wdata at rising edge when not full.
I_wdata  input  DSIZE  write data.
O_wfull  output  1  FIFO full (registered).
I_rinc  input  1  read request; pops head entry at rising edge when not empty.
O_rdata  output  DSIZE  head-of-FIFO data (show-ahead).
O_rempty  output  1  FIFO empty (registered).
O_level  output  ASIZE+1  occupancy count; present only with FIFO_LEVEL_EN.

Behaviour:
- Storage: 2**ASIZE x DSIZE array, no reset on contents; written at rising edge.
- Pointers: wptr and rptr are ASIZE+1 bits (extra wrap bit). Address = low ASIZE bits.
- Equality of all bits means empty. Address equality with opposite MSB means full.
- Reset (I_rst=1 at rising edge): wptr=0, rptr=0, O_rempty=1, O_wfull=0, O_level=0. Reset overrides any concurrent winc/rinc.
  - Memory contents are retained but unreachable after reset.
  - Reset asserted mid-transfer discards all queued data.
- Write accept: wen = I_winc & ~O_wfull. On wen, mem[wptr addr] <= I_wdata and wptr <= wptr+1.
- Read accept: ren = I_rinc & ~O_rempty. On ren, rptr <= rptr+1.
- Ignored requests:
  - Write while full: no memory write, no pointer change.
  - Read while empty: no pointer change.
- Flags are registered and computed from next-state pointers:
  - O_rempty <= (wptr_next == rptr_next).
  - O_wfull <= (wptr_next == {~rptr_next[ASIZE], rptr_next[ASIZE-1:0]}).
  - Flags are therefore exact, with no pessimistic lag.
- Latency: a word written at edge N is visible on O_rdata and O_rempty is low after edge N, so the first pop can occur at edge N+1.
- O_rdata: combinational mem[rptr addr] when O_rempty=0; forced to 0 when O_rempty=1.
  - After a pop at edge N, O_rdata shows the next entry after edge N.
- Simultaneous events:
  - winc & rinc with 0 < level < depth: both accepted; level unchanged; flags unchanged.
  - winc & rinc while empty: write accepted, read ignored; after the edge level=1 and O_rempty=0.
  - winc & rinc while full: read accepted, write ignored; after the edge level = depth-1 and O_wfull=0.
- Wrap-around: pointers roll naturally modulo 2**(ASIZE+1); ordering is preserved across the wrap.
- O_wfull and O_rempty are never both 1.

Optional Feature:
FIFO_LEVEL_EN
- Defined: O_level port exists and equals wptr - rptr (ASIZE+1 bits, range 0..2**ASIZE). It is registered, 0 after reset, and updated in the same cycle as the flags.
- Undefined: the O_level port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset 3 cycles, then hold idle -> O_rempty=1, O_wfull=0, O_rdata=0, O_level=0.
2. Write 1..30 on consecutive cycles; start reading 10 cycles after writes begin, for 30 cycles -> O_rdata sequence is 1..30 in order; O_rempty=1 after the last pop.
3. Write 1..80 and issue 81 reads -> 80 values 1..80 are popped; the 81st read is ignored; O_rempty stays 1 and the pointers do not move.
4. Write 1025 words with no reads -> O_wfull rises after the 1024th write; the 1025th word is dropped; draining returns exactly 1..1024 (low 8 bits, i.e. 1..255,0,1,...).
5. At full, assert winc and rinc together -> one pop; the write is ignored; O_wfull=0 and O_level=1023 afterwards. At empty, assert both -> one push; O_rempty=0 and O_level=1.
6. Write 90 and read 90 concurrently after prior traffic so the pointers cross the 1024 wrap -> data 1..90 in order; assert I_rst mid-stream -> next cycle O_rempty=1 and O_level=0, and subsequent writes restart cleanly.
